// File: rtl/arb_pkg.sv
// Shared types and constants for the memory-port arbiters.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

   localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin pick with lock priority and forced release on hold expiry.
module rr_pick
   import arb_pkg::*;
(
   input  logic [1:0]  req_i,
   input  logic        last_i,
   input  arb_state_e  state_i,
   input  logic        hold_exp_i,
   output logic [1:0]  gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (state_i)
         LOCK0: begin
            if (req_i[0] && !(hold_exp_i && req_i[1]))
               gnt_o = 2'b01;
            else if (req_i[1])
               gnt_o = 2'b10;
         end
         LOCK1: begin
            if (req_i[1] && !(hold_exp_i && req_i[0]))
               gnt_o = 2'b10;
            else if (req_i[0])
               gnt_o = 2'b01;
         end
         default: begin
            // On a tie the requester that did not win last time goes first.
            if (req_i == 2'b11)
               gnt_o = (last_i == REQ_CORE) ? 2'b10 : 2'b01;
            else
               gnt_o = req_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between core and DMA, with bounded bus lock.
// Define ARB_PERF_COUNTERS_EN to add grant/wait performance counters.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_COUNTERS_EN
   ,
   output logic [31:0]       perf_gnt0,
   output logic [31:0]       perf_gnt1,
   output logic [31:0]       perf_wait1
`endif
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   arb_state_e  state_q, state_d;
   logic        last_q, last_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        rd_pend_q, rd_pend_d;
   logic        rd_owner_q, rd_owner_d;

   logic [1:0]  req, lock, pick_gnt, gnt;
   logic        any_gnt, winner, win_lock, hold_exp, lock_owner;

   assign req        = {m1_req, m0_req};
   assign lock       = {m1_lock, m0_lock};
   assign hold_exp   = (hold_cnt_q >= HOLD_MAX);
   assign lock_owner = (state_q == LOCK1);

   rr_pick u_pick (
      .req_i      (req),
      .last_i     (last_q),
      .state_i    (state_q),
      .hold_exp_i (hold_exp),
      .gnt_o      (pick_gnt)
   );

   // Grants are combinational, so they must be masked while reset is held.
   assign gnt      = pick_gnt & {2{resetn}};
   assign any_gnt  = |gnt;
   assign winner   = gnt[1];
   assign win_lock = gnt[1] ? m1_lock : m0_lock;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         hold_cnt_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= REQ_CORE;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner_q;
      if (any_gnt) begin
         last_d = winner;
         if (!mem_we) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = winner;
         end
      end
      case (state_q)
         IDLE: begin
            if (any_gnt && win_lock) begin
               state_d    = winner ? LOCK1 : LOCK0;
               hold_cnt_d = 8'd1;
            end
         end
         LOCK0, LOCK1: begin
            if (gnt[lock_owner]) begin
               // Hold time only accrues while the other side is kept waiting.
               if (req[!lock_owner] && hold_cnt_q < HOLD_MAX)
                  hold_cnt_d = hold_cnt_q + 8'd1;
               if (!lock[lock_owner]) begin
                  state_d    = IDLE;
                  hold_cnt_d = '0;
               end
            end else if (any_gnt && win_lock) begin
               state_d    = winner ? LOCK1 : LOCK0;
               hold_cnt_d = 8'd1;
            end else begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      m0_gnt    = gnt[0];
      m1_gnt    = gnt[1];
      mem_en    = any_gnt;
      mem_we    = (gnt[0] & m0_we) | (gnt[1] & m1_we);
      mem_addr  = gnt[0] ? m0_addr  : (gnt[1] ? m1_addr  : '0);
      mem_wdata = gnt[0] ? m0_wdata : (gnt[1] ? m1_wdata : '0);
      m0_rvalid = rd_pend_q & (rd_owner_q == REQ_CORE);
      m1_rvalid = rd_pend_q & (rd_owner_q == REQ_DMA);
      m0_rdata  = m0_rvalid ? mem_rdata : '0;
      m1_rdata  = m1_rvalid ? mem_rdata : '0;
   end

`ifdef ARB_PERF_COUNTERS_EN
   logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_wait1_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_gnt0_q  <= '0;
         perf_gnt1_q  <= '0;
         perf_wait1_q <= '0;
      end else begin
         if (gnt[0])
            perf_gnt0_q <= perf_gnt0_q + 32'd1;
         if (gnt[1])
            perf_gnt1_q <= perf_gnt1_q + 32'd1;
         if (m1_req && !gnt[1])
            perf_wait1_q <= perf_wait1_q + 32'd1;
      end
   end

   assign perf_gnt0  = perf_gnt0_q;
   assign perf_gnt1  = perf_gnt1_q;
   assign perf_wait1 = perf_wait1_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a read-return scoreboard.
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_COUNTERS_EN
   logic [31:0]   perf_gnt0, perf_gnt1, perf_wait1;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic        owner;
      logic [31:0] data;
      int          due;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   rd_exp_t mon_e;
   logic [31:0] mem [0:255];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(HOLD)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef ARB_PERF_COUNTERS_EN
      , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_wait1(perf_wait1)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Memory macro model: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            mem[mem_addr[7:0]] <= mem_wdata;
         else
            mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return 32'hC0DE0000 ^ {24'd0, a[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r0, w0, l0, input logic [31:0] a0, d0,
                        input logic r1, w1, l1, input logic [31:0] a1, d1);
      m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
   endtask

   task automatic expect_read(input logic owner, input logic [31:0] data);
      rd_exp_t e;
      e.owner = owner;
      e.data  = data;
      e.due   = cyc + 1;
      rd_q.push_back(e);
   endtask

   // Scoreboard: every rvalid must match the oldest outstanding read, on time.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
            checks++;
            if (m0_rvalid === 1'b1 && m1_rvalid === 1'b1) begin
               errors++;
               $display("FAIL rvalid_both cyc=%0d got m0=1 m1=1 exp one-hot", cyc);
            end else if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rvalid_unexpected cyc=%0d got m0=%b m1=%b exp none", cyc, m0_rvalid, m1_rvalid);
            end else begin
               mon_e = rd_q.pop_front();
               if (m1_rvalid !== mon_e.owner || mon_e.due != cyc ||
                   (m1_rvalid ? m1_rdata : m0_rdata) !== mon_e.data ||
                   (m1_rvalid ? m0_rdata : m1_rdata) !== 32'd0) begin
                  errors++;
                  $display("FAIL rd_return cyc=%0d got owner=%b data=%h other=%h exp owner=%b data=%h other=0 due=%0d",
                           cyc, m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata,
                           m1_rvalid ? m0_rdata : m1_rdata, mon_e.owner, mon_e.data, mon_e.due);
               end
            end
         end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing cyc=%0d got none exp owner=%b data=%h", cyc, rd_q[0].owner, rd_q[0].data);
            void'(rd_q.pop_front());
         end
      end
   end

   task automatic test_reset();
      resetn = 1'b0;
      drive(1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
      repeat (2) tick();
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid} !== 6'b0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL reset_outputs got gnt=%b%b en=%b we=%b rv=%b%b addr=%h exp all 0",
                  m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid, mem_addr);
      end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL first_tie got gnt=%b%b en=%b we=%b addr=%h exp gnt=10 en=1 we=0 addr=10",
                  m0_gnt, m1_gnt, mem_en, mem_we, mem_addr);
      end
      expect_read(1'b0, init_word(32'h10));
      $display("txn reset_release: m0 read 0x10 granted=%b", m0_gnt);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 32'h20 || m0_rvalid !== 1'b1 ||
          m0_rdata !== init_word(32'h10)) begin
         errors++;
         $display("FAIL second_grant got gnt=%b%b addr=%h rv0=%b rd0=%h exp gnt=01 addr=20 rv0=1 rd0=%h",
                  m0_gnt, m1_gnt, mem_addr, m0_rvalid, m0_rdata, init_word(32'h10));
      end
      expect_read(1'b1, init_word(32'h20));
      $display("txn reset_release: m1 read 0x20 granted=%b", m1_gnt);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL idle_port got en=%b wdata=%h exp en=0 wdata=0", mem_en, mem_wdata);
      end
      tick();
   endtask

   task automatic test_write_only();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL m1_write got gnt=%b%b en=%b we=%b addr=%h wd=%h exp gnt=01 en=1 we=1 addr=40 wd=deadbeef",
                  m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      $display("txn write: m1 wr 0x40=deadbeef granted=%b", m1_gnt);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL write_no_rvalid got rv=%b%b exp 00", m0_rvalid, m1_rvalid);
      end
      tick();
      drive(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL readback_gnt got gnt=%b%b exp 10", m0_gnt, m1_gnt);
      end
      expect_read(1'b0, 32'hDEADBEEF);
      $display("txn write: m0 readback 0x40");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_lock_hold();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL m1_alone got gnt=%b%b exp 01", m0_gnt, m1_gnt);
      end
      expect_read(1'b1, init_word(32'h30));
      tick();
      drive(1, 0, 1, 32'h60, 0, 1, 0, 0, 32'h50, 0);
      for (int k = 1; k <= HOLD; k++) begin
         @(negedge clk);
         checks++;
         if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_hold_%0d got gnt=%b%b exp 10", k, m0_gnt, m1_gnt);
         end
         expect_read(1'b0, init_word(32'h60));
         $display("txn lock_hold: cycle %0d gnt=%b%b", k, m0_gnt, m1_gnt);
         tick();
      end
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 32'h50) begin
         errors++;
         $display("FAIL forced_release got gnt=%b%b addr=%h exp gnt=01 addr=50", m0_gnt, m1_gnt, mem_addr);
      end
      expect_read(1'b1, init_word(32'h50));
      $display("txn lock_hold: forced release gnt=%b%b", m0_gnt, m1_gnt);
      tick();
      drive(1, 0, 0, 32'h64, 0, 1, 0, 0, 32'h54, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL idle_after_release got gnt=%b%b exp 10", m0_gnt, m1_gnt);
      end
      expect_read(1'b0, init_word(32'h64));
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h54, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL m1_after_release got gnt=%b%b exp 01", m0_gnt, m1_gnt);
      end
      expect_read(1'b1, init_word(32'h54));
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_hold_uncontended();
      drive(1, 1, 1, 32'h90, 32'h11, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_alone_%0d got gnt=%b%b exp 10", k, m0_gnt, m1_gnt);
         end
         tick();
      end
      drive(1, 1, 1, 32'h90, 32'h11, 1, 1, 0, 32'h94, 32'h22);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({m0_gnt, m1_gnt} !== ((k < HOLD - 1) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL hold_contended_%0d got gnt=%b%b exp %b", k, m0_gnt, m1_gnt,
                     (k < HOLD - 1) ? 2'b10 : 2'b01);
         end
         $display("txn hold_contended: cycle %0d gnt=%b%b", k, m0_gnt, m1_gnt);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_lock_drop();
      drive(1, 1, 1, 32'h70, 32'hA1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, mem_we} !== 3'b101 || mem_wdata !== 32'hA1) begin
         errors++;
         $display("FAIL lock_take got gnt=%b%b we=%b wd=%h exp gnt=10 we=1 wd=a1", m0_gnt, m1_gnt, mem_we, mem_wdata);
      end
      tick();
      drive(1, 1, 0, 32'h74, 32'hA2, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10 || mem_addr !== 32'h74) begin
         errors++;
         $display("FAIL lock_drop got gnt=%b%b addr=%h exp gnt=10 addr=74", m0_gnt, m1_gnt, mem_addr);
      end
      tick();
      drive(1, 1, 0, 32'h78, 32'hA3, 1, 1, 0, 32'h7C, 32'hB3);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 32'h7C || mem_wdata !== 32'hB3) begin
         errors++;
         $display("FAIL tie_after_drop got gnt=%b%b addr=%h wd=%h exp gnt=01 addr=7c wd=b3",
                  m0_gnt, m1_gnt, mem_addr, mem_wdata);
      end
      $display("txn lock_drop: tie gnt=%b%b", m0_gnt, m1_gnt);
      tick();
      drive(1, 1, 0, 32'h78, 32'hA3, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL m0_after_tie got gnt=%b%b exp 10", m0_gnt, m1_gnt);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset_midread();
      drive(1, 0, 0, 32'h18, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL midread_gnt got gnt=%b%b exp 10", m0_gnt, m1_gnt);
      end
      @(posedge clk);
      #1;
      resetn = 1'b0;
      drive(1, 1, 0, 32'h18, 32'h5, 1, 1, 0, 32'h28, 32'h6);
      #1;
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid} !== 6'b0) begin
         errors++;
         $display("FAIL midread_reset_outputs got gnt=%b%b en=%b we=%b rv=%b%b exp all 0",
                  m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid);
      end
      rd_q.delete();
      #2;
      resetn = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_dropped got rv=%b%b exp 00", m0_rvalid, m1_rvalid);
      end
      $display("txn reset_midread: rvalid after reset=%b%b", m0_rvalid, m1_rvalid);
      tick();
      drive(1, 1, 0, 32'hA0, 32'h7, 1, 1, 0, 32'hA4, 32'h8);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL tie_after_reset got gnt=%b%b exp 10", m0_gnt, m1_gnt);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 32'hA4, 32'h8);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

`ifdef ARB_PERF_COUNTERS_EN
   task automatic test_perf();
      logic [31:0] s0, s1, sw;
      s0 = perf_gnt0;
      s1 = perf_gnt1;
      sw = perf_wait1;
      drive(1, 1, 0, 32'hB0, 32'h1, 1, 1, 0, 32'hB4, 32'h2);
      repeat (10) tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (perf_gnt0 - s0 !== 32'd5 || perf_gnt1 - s1 !== 32'd5 || perf_wait1 - sw !== 32'd5) begin
         errors++;
         $display("FAIL perf_counts got g0=%0d g1=%0d w1=%0d exp 5 5 5",
                  perf_gnt0 - s0, perf_gnt1 - s1, perf_wait1 - sw);
      end
      $display("txn perf: g0=%0d g1=%0d w1=%0d", perf_gnt0 - s0, perf_gnt1 - s1, perf_wait1 - sw);
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = init_word(32'(i));
      test_reset();
      test_write_only();
      test_lock_hold();
      test_hold_uncontended();
      test_lock_drop();
      test_reset_midread();
`ifdef ARB_PERF_COUNTERS_EN
      test_perf();
`endif
      tick();
      tick();
      checks++;
      if (rd_q.size() != 0) begin
         errors++;
         $display("FAIL reads_outstanding got %0d exp 0", rd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
